// File: rtl/qed_dup_buffer.sv
// Records constrained original instructions and replays them as register/offset-shifted QED duplicates.
// Latency 1 cycle accept/pop -> qed_instr; stall freezes every register and deasserts ifu_ready.

// Circular FIFO: 0-cycle read of the head, 1-cycle write; the caller never pushes and pops together.
// No internal backpressure: the caller gates push with full and pop with count.
module qed_fifo #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     head,
  output logic [PTR_W:0]   count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
      count  <= count + 1'b1;
    end else if (pop) begin
      rd_ptr <= rd_ptr + 1'b1;
      count  <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

module qed_dup_buffer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ifu_instr,
  input  logic             ifu_valid,
  input  logic             exec_dup,
  input  logic             stall,
  output logic             ifu_ready,
  output logic [31:0]      qed_instr,
  output logic             qed_vld,
  output logic             qed_ready,
  output logic [PTR_W:0]   buf_count
);

  typedef enum logic {ORIG, DUP} state_t;

  localparam logic [31:0]      NOP_INSTR = 32'h0000_007F;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   ONE       = (PTR_W+1)'(1);

  state_t           state_q, state_d;
  logic [31:0]      instr_d;
  logic             vld_d, ready_d;
  logic [CNT_W-1:0] num_orig, num_orig_d;
  logic [CNT_W-1:0] num_dup, num_dup_d;
  logic             sat_q, sat_d;
  logic [PTR_W:0]   count, cnt_d;
  logic [31:0]      head;
  logic             push, pop, take_dup, full, is_nop;

  function automatic logic [31:0] dup_xform(input logic [31:0] i);
    logic [31:0] o;
    o = i;
    case (i[6:0])
      7'b0110011: begin o[11] = 1'b1; o[19] = 1'b1; o[24] = 1'b1; end
      7'b0010011: begin o[11] = 1'b1; o[19] = 1'b1; end
      7'b0000011: begin o[11] = 1'b1; o[30] = 1'b1; end
      7'b0100011: begin o[24] = 1'b1; o[30] = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  qed_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .W(32)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (ifu_instr),
    .head  (head),
    .count (count)
  );

  assign full      = (count == FULL_CNT);
  assign take_dup  = exec_dup && (count != '0);
  assign is_nop    = (ifu_instr[6:0] == 7'b1111111);
  assign ifu_ready = (state_q == ORIG) && !full && !stall && !take_dup;
  assign buf_count = count;

  always_comb begin
    state_d    = state_q;
    instr_d    = qed_instr;
    vld_d      = qed_vld;
    num_orig_d = num_orig;
    num_dup_d  = num_dup;
    cnt_d      = count;
    push       = 1'b0;
    pop        = 1'b0;
    if (!stall) begin
      unique case (state_q)
        ORIG: begin
          if (take_dup) begin
            pop       = 1'b1;
            instr_d   = dup_xform(head);
            vld_d     = 1'b1;
            num_dup_d = sat_inc(num_dup);
            cnt_d     = count - 1'b1;
            state_d   = (count > ONE) ? DUP : ORIG;
          end else if (ifu_valid && ifu_ready) begin
            instr_d = ifu_instr;
            vld_d   = 1'b1;
            if (!is_nop) begin
              push       = 1'b1;
              num_orig_d = sat_inc(num_orig);
              cnt_d      = count + 1'b1;
            end
          end else begin
            instr_d = NOP_INSTR;
            vld_d   = 1'b0;
          end
        end
        DUP: begin
          if (count != '0) begin
            pop       = 1'b1;
            instr_d   = dup_xform(head);
            vld_d     = 1'b1;
            num_dup_d = sat_inc(num_dup);
            cnt_d     = count - 1'b1;
            if (count == ONE) state_d = ORIG;
          end else begin
            instr_d = NOP_INSTR;
            vld_d   = 1'b0;
            state_d = ORIG;
          end
        end
      endcase
    end
    // Saturation is sticky so a wrapped-looking balance can never report ready.
    sat_d   = sat_q || (num_orig_d == CNT_MAX) || (num_dup_d == CNT_MAX);
    ready_d = stall ? qed_ready
                    : (!sat_d && (num_orig_d == num_dup_d) && (num_orig_d != '0) &&
                       (cnt_d == '0) && (state_d == ORIG));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ORIG;
      qed_instr <= NOP_INSTR;
      qed_vld   <= 1'b0;
      qed_ready <= 1'b0;
      num_orig  <= '0;
      num_dup   <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      qed_instr <= instr_d;
      qed_vld   <= vld_d;
      qed_ready <= ready_d;
      num_orig  <= num_orig_d;
      num_dup   <= num_dup_d;
      sat_q     <= sat_d;
    end
  end

endmodule

// File: tb/tb_qed_dup_buffer.sv
// Directed vector bench for qed_dup_buffer: table of single-cycle vectors plus multi-cycle sequences.
module tb_qed_dup_buffer;

  localparam logic [31:0] NOP  = 32'h0000_007F;
  localparam logic [31:0] ADD  = 32'h0031_00B3;
  localparam logic [31:0] ADDD = 32'h0139_08B3;
  localparam logic [31:0] LW   = 32'h0040_2283;
  localparam logic [31:0] SW   = 32'h0060_2423;
  localparam logic [31:0] ADDI = 32'h0051_0093;

  logic        clk = 1'b0;
  logic        rst, ifu_valid, exec_dup, stall;
  logic [31:0] ifu_instr;
  logic        ifu_ready, qed_vld, qed_ready;
  logic [31:0] qed_instr;
  logic [3:0]  buf_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  qed_dup_buffer #(.DEPTH(8), .PTR_W(3), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ifu_instr (ifu_instr),
    .ifu_valid (ifu_valid),
    .exec_dup  (exec_dup),
    .stall     (stall),
    .ifu_ready (ifu_ready),
    .qed_instr (qed_instr),
    .qed_vld   (qed_vld),
    .qed_ready (qed_ready),
    .buf_count (buf_count)
  );

  typedef struct {
    logic        r, v, d, s;
    logic [31:0] ins;
    logic        e_rdy;
    logic [31:0] e_ins;
    logic        e_vld, e_qrdy;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t tbl[13];

  // ADDI x1,x2,(i+1): distinct non-NOP I-type instructions
  function automatic logic [31:0] mk(input int i);
    return {12'(i + 1), 5'd2, 3'd0, 5'd1, 7'b0010011};
  endfunction

  function automatic logic [31:0] mkd(input int i);
    return mk(i) | 32'h0008_0800;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (vector %0d)", nm, got, exp, n_vec);
    end
  endtask

  task automatic step(input logic r, v, d, s, input logic [31:0] ins,
                      input logic e_rdy, input logic [31:0] e_ins,
                      input logic e_vld, input logic e_qrdy, input logic [3:0] e_cnt);
    @(negedge clk);
    rst = r; ifu_valid = v; exec_dup = d; stall = s; ifu_instr = ins;
    #1;
    chk("ifu_ready", 32'(ifu_ready), 32'(e_rdy));
    @(posedge clk);
    #1;
    chk("qed_instr", qed_instr, e_ins);
    chk("qed_vld", 32'(qed_vld), 32'(e_vld));
    if (!$isunknown(e_qrdy)) chk("qed_ready", 32'(qed_ready), 32'(e_qrdy));
    chk("buf_count", 32'(buf_count), 32'(e_cnt));
    n_vec++;
  endtask

  initial begin
    //            r  v  d  s  ins    | rdy e_ins  vld qrdy cnt
    tbl[0]  = '{0, 0, 0, 0, 32'h0, 1, NOP,  0, 0, 0};  // held in reset
    tbl[1]  = '{1, 1, 0, 0, ADD,   1, ADD,  1, 0, 1};
    tbl[2]  = '{1, 0, 1, 0, 32'h0, 0, ADDD, 1, 1, 0};  // single dup stays ORIG
    tbl[3]  = '{1, 0, 0, 0, 32'h0, 1, NOP,  0, 1, 0};
    tbl[4]  = '{1, 1, 0, 0, LW,    1, LW,   1, 0, 1};
    tbl[5]  = '{1, 1, 0, 0, SW,    1, SW,   1, 0, 2};
    tbl[6]  = '{1, 0, 1, 0, 32'h0, 0, 32'h4040_2A83, 1, 0, 1};
    tbl[7]  = '{1, 1, 0, 0, ADDI,  0, 32'h4160_2423, 1, 1, 0};  // DUP ignores ifu_valid
    tbl[8]  = '{1, 1, 0, 0, NOP,   1, NOP,  1, 1, 0};  // NOP passes, not recorded
    tbl[9]  = '{1, 1, 1, 0, ADDI,  1, ADDI, 1, 0, 1};  // exec_dup on empty FIFO
    tbl[10] = '{1, 1, 1, 0, ADD,   0, 32'h0059_0893, 1, 1, 0};  // instr dropped
    tbl[11] = '{1, 0, 0, 0, 32'h0, 1, NOP,  0, 1, 0};
    tbl[12] = '{1, 1, 0, 1, ADD,   0, NOP,  0, 1, 0};  // stall in ORIG holds

    rst = 1'b0; ifu_valid = 1'b0; exec_dup = 1'b0; stall = 1'b0; ifu_instr = '0;
    @(posedge clk);

    for (int i = 0; i < 13; i++)
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].ins,
           tbl[i].e_rdy, tbl[i].e_ins, tbl[i].e_vld, tbl[i].e_qrdy, tbl[i].e_cnt);

    // Fill to full (pointers start mid-buffer), 9th refused, then replay across the wrap
    for (int i = 0; i < 8; i++)
      step(1, 1, 0, 0, mk(i), 1, mk(i), 1, 0, 4'(i + 1));
    step(1, 1, 0, 0, mk(8), 0, NOP, 0, 0, 8);
    for (int k = 0; k < 8; k++)
      step(1, 0, (k == 0), 0, 32'h0, 0, mkd(k), 1, (k == 7), 4'(7 - k));

    // Second full round
    for (int i = 0; i < 8; i++)
      step(1, 1, 0, 0, mk(30 + i), 1, mk(30 + i), 1, 0, 4'(i + 1));
    for (int k = 0; k < 8; k++)
      step(1, 0, (k == 0), 0, 32'h0, 0, mkd(30 + k), 1, (k == 7), 4'(7 - k));

    // Stall for 3 cycles mid-DUP, resume, then reset mid-DUP
    for (int i = 0; i < 4; i++)
      step(1, 1, 0, 0, mk(20 + i), 1, mk(20 + i), 1, 0, 4'(i + 1));
    step(1, 0, 1, 0, 32'h0, 0, mkd(20), 1, 0, 3);
    for (int k = 0; k < 3; k++)
      step(1, 1, 1, 1, ADD, 0, mkd(20), 1, 0, 3);
    step(1, 0, 0, 0, 32'h0, 0, mkd(21), 1, 0, 2);
    step(0, 0, 0, 0, 32'h0, 0, NOP, 0, 0, 0);
    step(1, 1, 0, 0, ADD, 1, ADD, 1, 0, 1);
    step(1, 0, 1, 0, 32'h0, 0, ADDD, 1, 1, 0);  // counters were cleared by reset

    // Counter saturation: once a counter is pinned at 255, ready never returns
    step(0, 0, 0, 0, 32'h0, 1, NOP, 0, 0, 0);
    for (int n = 1; n <= 257; n++) begin
      step(1, 1, 0, 0, ADD, 1, ADD, 1, 0, 1);
      step(1, 0, 1, 0, 32'h0, 0, ADDD, 1,
           (n <= 254) ? 1'b1 : (n == 255) ? 1'bx : 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
